// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-side fetch miss path and the D-side miss/write path.
// Optional watchdog compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 128,
    parameter int MAX_D_WINS     = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_rdata,
    output logic              ic_stall,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              dc_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err,
    output logic [1:0]        o_dbg_state,
    output logic [3:0]        o_dbg_d_win_cnt
);

    // Handshake: ic_req/dc_req are held high until the matching one-cycle ack;
    // mem_req is a level held until the one-cycle mem_ack. No grant is made in RESP.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] L_MAX_D = 4'(MAX_D_WINS);

    generate
        if (MAX_D_WINS < 1 || MAX_D_WINS > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
            $error("mem_port_arbiter: parameter out of range");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner_d;
    logic [3:0]        r_d_win_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [LINE_W-1:0] r_ic_rdata;
    logic [LINE_W-1:0] r_dc_rdata;

    logic              w_contested;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_in_busy;
    logic              w_timeout;
    logic              w_done;
    logic [LINE_W-1:0] w_resp_data;

    assign w_contested = ic_req & dc_req;
    // D wins unless I is also waiting and D has already won MAX_D_WINS contested rounds.
    assign w_grant_d   = dc_req & (~ic_req | (r_d_win_cnt < L_MAX_D));
    assign w_grant_i   = ic_req & ~w_grant_d;
    assign w_in_busy   = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] L_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wd_cnt;
    logic       r_err;

    // A mem_ack in the timeout cycle takes precedence, so it is excluded here.
    assign w_timeout = w_in_busy & ~mem_ack & (r_wd_cnt == L_TO_LAST);
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_in_busy) begin
                r_wd_cnt <= r_wd_cnt + 8'd1;
            end else begin
                r_wd_cnt <= 8'd0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign w_done      = w_in_busy & (mem_ack | w_timeout);
    assign w_resp_data = mem_ack ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = S_BUSY_D;
                end else if (w_grant_i) begin
                    w_state_nxt = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (w_done) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        busy    = 1'b0;
        ic_ack  = 1'b0;
        dc_ack  = 1'b0;
        case (r_state)
            S_BUSY_I, S_BUSY_D: begin
                mem_req = 1'b1;
                busy    = 1'b1;
            end
            S_RESP: begin
                busy   = 1'b1;
                ic_ack = ~r_owner_d;
                dc_ack = r_owner_d;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_d   <= 1'b0;
            r_d_win_cnt <= 4'd0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_ic_rdata  <= '0;
            r_dc_rdata  <= '0;
        end else begin
            if ((r_state == S_IDLE) && (w_grant_d || w_grant_i)) begin
                r_owner_d   <= w_grant_d;
                r_mem_addr  <= w_grant_d ? dc_addr : ic_addr;
                r_mem_we    <= w_grant_d & dc_we;
                r_mem_wdata <= w_grant_d ? dc_wdata : '0;
                r_d_win_cnt <= (w_grant_d && w_contested) ? r_d_win_cnt + 4'd1 : 4'd0;
            end
            if (w_done) begin
                if (r_owner_d) begin
                    r_dc_rdata <= w_resp_data;
                end else begin
                    r_ic_rdata <= w_resp_data;
                end
            end
        end
    end

    assign mem_addr        = r_mem_addr;
    assign mem_we          = r_mem_we;
    assign mem_wdata       = r_mem_wdata;
    assign ic_rdata        = r_ic_rdata;
    assign dc_rdata        = r_dc_rdata;
    assign ic_stall        = ic_req & ~ic_ack;
    assign dc_stall        = dc_req & ~dc_ack;
    assign o_dbg_state     = r_state;
    assign o_dbg_d_win_cnt = r_d_win_cnt;

endmodule
